ddr_req_axi_bridge: RTL and testbench

//  Responder for the ddr_req/ddr_ready local request interface, used by the UART buffering logic and other PL requesters.

---
 rtl/ddr_req_axi_bridge.sv | 152 +++++++++++++++
 tb/tb_ddr_req_axi_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_req_axi_bridge.sv
// ddr_req_axi_bridge: turns each ddr_req request into one single-beat AXI3 write (AW+W+B) or read (AR+R).
// Only one transaction is outstanding at a time.
// Optional feature: define DDR_ADDR_CHECK_EN to turn away requests outside [AddrLo, AddrHi] without touching AXI.
// Ports:
//   clk, reset                           clock, asynchronous active-high reset
//   ddr_req/addr/wdata/wstrb             request; a nonzero wstrb means write, a zero wstrb means read
//   ddr_rdata, ddr_ready, ddr_busy, err  read data, completion pulse, busy flag, sticky error flag
//   axi_aw*/w*/b*                        AXI3 write address, write data and write response channels
//   axi_ar*/r*                           AXI3 read address and read data channels
module ddr_req_axi_bridge #(
  parameter int AddrW = 32,
  parameter int DataW = 64,
  parameter logic [AddrW-1:0] AddrLo = 32'h0010_0000,
  parameter logic [AddrW-1:0] AddrHi = 32'h3FFF_FFFF,
  localparam int StrbW = DataW / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ddr_req,
  input  logic [AddrW-1:0] ddr_addr,
  input  logic [DataW-1:0] ddr_wdata,
  input  logic [StrbW-1:0] ddr_wstrb,
  output logic [DataW-1:0] ddr_rdata,
  output logic             ddr_ready,
  output logic             ddr_busy,
  output logic             err,
  output logic [AddrW-1:0] axi_awaddr,
  output logic             axi_awvalid,
  input  logic             axi_awready,
  output logic [3:0]       axi_awlen,
  output logic [2:0]       axi_awsize,
  output logic [1:0]       axi_awburst,
  output logic [DataW-1:0] axi_wdata,
  output logic [StrbW-1:0] axi_wstrb,
  output logic             axi_wlast,
  output logic             axi_wvalid,
  input  logic             axi_wready,
  input  logic [1:0]       axi_bresp,
  input  logic             axi_bvalid,
  output logic             axi_bready,
  output logic [AddrW-1:0] axi_araddr,
  output logic             axi_arvalid,
  input  logic             axi_arready,
  output logic [3:0]       axi_arlen,
  output logic [2:0]       axi_arsize,
  output logic [1:0]       axi_arburst,
  input  logic [DataW-1:0] axi_rdata,
  input  logic [1:0]       axi_rresp,
  input  logic             axi_rvalid,
  input  logic             axi_rlast,
  output logic             axi_rready
);
  typedef enum logic [2:0] {IDLE, WR, BWAIT, RD, RWAIT, RDONE, REJECT} state_t;
  state_t state;
  logic [AddrW-4:0] addr_q;
  logic bad_addr;
  logic unused_rlast;
  assign unused_rlast = axi_rlast;
`ifdef DDR_ADDR_CHECK_EN
  assign bad_addr = ddr_addr < AddrLo || ddr_addr > AddrHi;
`else
  logic unused_range;
  assign unused_range = ^{AddrLo, AddrHi};
  assign bad_addr = 1'b0;
`endif
  assign axi_awaddr = {addr_q, 3'b000};
  assign axi_araddr = {addr_q, 3'b000};
  assign axi_awlen = 4'd0;
  assign axi_arlen = 4'd0;
  assign axi_awsize = 3'd3;
  assign axi_arsize = 3'd3;
  assign axi_awburst = 2'b01;
  assign axi_arburst = 2'b01;
  assign axi_wlast = axi_wvalid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      ddr_rdata <= '0;
      ddr_ready <= 1'b0;
      ddr_busy <= 1'b0;
      err <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid <= 1'b0;
      axi_wdata <= '0;
      axi_wstrb <= '0;
      axi_bready <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready <= 1'b0;
    end else begin
      ddr_ready <= 1'b0;
      case (state)
        IDLE: if (ddr_req) begin
          addr_q <= ddr_addr[AddrW-1:3];
          axi_wdata <= ddr_wdata;
          axi_wstrb <= ddr_wstrb;
          ddr_busy <= 1'b1;
          if (bad_addr) begin
            state <= REJECT;
            err <= 1'b1;
          end else if (|ddr_wstrb) begin
            state <= WR;
            axi_awvalid <= 1'b1;
            axi_wvalid <= 1'b1;
          end else begin
            state <= RD;
            axi_arvalid <= 1'b1;
          end
        end
        WR: begin
          // each channel drops its valid on its own handshake; move on once neither is pending
          if (axi_awready) axi_awvalid <= 1'b0;
          if (axi_wready) axi_wvalid <= 1'b0;
          if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
            state <= BWAIT;
            axi_bready <= 1'b1;
            ddr_ready <= 1'b1;
          end
        end
        BWAIT: if (axi_bvalid) begin
          state <= IDLE;
          axi_bready <= 1'b0;
          ddr_busy <= 1'b0;
          if (|axi_bresp) err <= 1'b1;
        end
        RD: if (axi_arready) begin
          state <= RWAIT;
          axi_arvalid <= 1'b0;
          axi_rready <= 1'b1;
        end
        RWAIT: if (axi_rvalid) begin
          state <= RDONE;
          axi_rready <= 1'b0;
          ddr_rdata <= axi_rdata;
          ddr_ready <= 1'b1;
          if (|axi_rresp) err <= 1'b1;
        end
        RDONE: begin
          state <= IDLE;
          ddr_busy <= 1'b0;
        end
        REJECT: begin
          // the pulse is given from RDONE so the still-high request is not re-sampled in IDLE
          state <= RDONE;
          ddr_ready <= 1'b1;
          if (axi_wstrb == '0) ddr_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_req_axi_bridge.sv
// tb_ddr_req_axi_bridge: directed scoreboard bench for ddr_req_axi_bridge with a delay-configurable AXI slave.
module tb_ddr_req_axi_bridge;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic ddr_req = 0;
  logic [31:0] ddr_addr = 0;
  logic [63:0] ddr_wdata = 0;
  logic [7:0] ddr_wstrb = 0;
  logic [63:0] ddr_rdata;
  logic ddr_ready, ddr_busy, err;
  logic [31:0] axi_awaddr, axi_araddr;
  logic axi_awvalid, axi_arvalid, axi_wvalid, axi_wlast, axi_bready, axi_rready;
  logic axi_awready = 0, axi_arready = 0, axi_wready = 0, axi_bvalid = 0, axi_rvalid = 0, axi_rlast = 1;
  logic [3:0] axi_awlen, axi_arlen;
  logic [2:0] axi_awsize, axi_arsize;
  logic [1:0] axi_awburst, axi_arburst;
  logic [63:0] axi_wdata;
  logic [7:0] axi_wstrb;
  logic [1:0] axi_bresp = 0, axi_rresp = 0;
  logic [63:0] axi_rdata = 0;

  ddr_req_axi_bridge dut (
    .clk(clk), .reset(reset), .ddr_req(ddr_req), .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata),
    .ddr_wstrb(ddr_wstrb), .ddr_rdata(ddr_rdata), .ddr_ready(ddr_ready), .ddr_busy(ddr_busy), .err(err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast),
    .axi_rready(axi_rready)
  );

  typedef struct {logic rd; logic [63:0] rdata; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_err = 0, cyc = 0, req_cyc = 0, readys = 0, n_txn = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_c = 0, rresp_c = 0;
  logic [63:0] rdata_c = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_wait = 0, r_wait = 0;
  logic b_fire = 0, r_fire = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [31:0] last_awaddr = 0, last_araddr = 0;
  logic [63:0] last_wdata = 0;
  logic [7:0] last_wstrb = 0;
  logic last_wlast = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // AXI slave: readies after a configurable wait, responses a configurable number of cycles after the data/address handshake
  always @(negedge clk) begin
    if (reset) begin
      axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_bvalid = 0; axi_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0; b_fire = 0; r_fire = 0;
    end else begin
      if (b_fire) begin axi_bvalid = 0; b_fire = 0; end
      if (r_fire) begin axi_rvalid = 0; r_fire = 0; end
      if (b_wait > 0) begin
        b_wait--;
        if (b_wait == 0) begin axi_bvalid = 1; axi_bresp = bresp_c; end
      end
      if (r_wait > 0) begin
        r_wait--;
        if (r_wait == 0) begin axi_rvalid = 1; axi_rdata = rdata_c; axi_rresp = rresp_c; end
      end
      axi_awready = axi_awvalid && aw_cnt >= aw_dly;
      aw_cnt = axi_awvalid ? aw_cnt + 1 : 0;
      axi_wready = axi_wvalid && w_cnt >= w_dly;
      w_cnt = axi_wvalid ? w_cnt + 1 : 0;
      axi_arready = axi_arvalid && ar_cnt >= ar_dly;
      ar_cnt = axi_arvalid ? ar_cnt + 1 : 0;
      if (axi_awvalid && axi_awready) begin aw_hs++; last_awaddr = axi_awaddr; end
      if (axi_wvalid && axi_wready) begin
        w_hs++; last_wdata = axi_wdata; last_wstrb = axi_wstrb; last_wlast = axi_wlast; b_wait = b_dly + 1;
      end
      if (axi_arvalid && axi_arready) begin ar_hs++; last_araddr = axi_araddr; r_wait = r_dly + 1; end
      if (axi_bvalid && axi_bready) b_fire = 1;
      if (axi_rvalid && axi_rready) r_fire = 1;
    end
  end

  // monitor: every ddr_ready pulse consumes one expected completion
  always @(negedge clk) begin
    if (!reset && ddr_ready) begin
      readys++;
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL ready_unexpected: got pulse expected none");
      end else begin
        e = sb.pop_front();
        chk("ready_latency", 64'(cyc - req_cyc), 64'(e.lat));
        if (e.rd) chk("ddr_rdata", ddr_rdata, e.rdata);
      end
    end
  end

  task automatic txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                     input logic [63:0] exp_rd, input int lat);
    int t;
    sb.push_back('{s == 0, exp_rd, lat});
    n_txn++;
    @(negedge clk);
    ddr_addr = a; ddr_wdata = d; ddr_wstrb = s; ddr_req = 1; req_cyc = cyc;
    t = 0;
    do begin @(negedge clk); t++; end while (!ddr_ready && t < 100);
    if (!ddr_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: got no ddr_ready expected pulse for addr %0h", a);
    end
    ddr_req = 0;
    t = 0;
    while (ddr_busy && t < 100) begin @(negedge clk); t++; end
    chk("busy_after_txn", 64'(ddr_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar0, t;
    repeat (3) @(negedge clk);
    chk("reset_outs", {ddr_ready, ddr_busy, err, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 0);
    chk("reset_rdata", ddr_rdata, 0);
    chk("const_len_size_burst", {axi_awlen, axi_awsize, axi_awburst, axi_arlen, axi_arsize, axi_arburst}, 18'h0_D_0_D >> 0 == 0 ? 0 : {4'd0, 3'd3, 2'b01, 4'd0, 3'd3, 2'b01});
    reset = 0;
    b_dly = 2;
    txn(32'h1000_0010, 64'h5A, 8'hFF, 0, 2);
    chk("t1_aw_hs", 64'(aw_hs), 1);
    chk("t1_w_hs", 64'(w_hs), 1);
    chk("t1_awaddr", last_awaddr, 32'h1000_0010);
    chk("t1_wdata", last_wdata, 64'h5A);
    chk("t1_wstrb", last_wstrb, 8'hFF);
    chk("t1_wlast", last_wlast, 1);
    chk("t1_err", err, 0);
    ar_dly = 1; r_dly = 2; rdata_c = 64'h5A;
    txn(32'h1000_0010, 0, 0, 64'h5A, 6);
    chk("t2_ar_hs", 64'(ar_hs), 1);
    chk("t2_araddr", last_araddr, 32'h1000_0010);
    chk("t2_err", err, 0);
    ar_dly = 0; r_dly = 0; w_dly = 4; b_dly = 0;
    txn(32'h2000_0008, 64'h0123_4567_89AB_CDEF, 8'h0F, 0, 6);
    chk("t3_aw_hs", 64'(aw_hs), 2);
    chk("t3_w_hs", 64'(w_hs), 2);
    chk("t3_wdata", last_wdata, 64'h0123_4567_89AB_CDEF);
    chk("t3_wstrb", last_wstrb, 8'h0F);
    chk("t3_rdata_hold", ddr_rdata, 64'h5A);
    rdata_c = 64'hDEAD_BEEF_0000_1111;
    txn(32'h1000_0020, 0, 0, 64'hDEAD_BEEF_0000_1111, 3);
    chk("tmin_ar_hs", 64'(ar_hs), 2);
    w_dly = 0; bresp_c = 2'b10;
    txn(32'h1000_0017, 64'hFFEE, 8'h01, 0, 2);
    chk("t4_awaddr_align", last_awaddr, 32'h1000_0010);
    chk("t4_err_set", err, 1);
    bresp_c = 0; rdata_c = 64'h77;
    txn(32'h1000_0030, 0, 0, 64'h77, 3);
    chk("t4_err_sticky", err, 1);
    r_dly = 10;
    @(negedge clk);
    ddr_addr = 32'h1000_0040; ddr_wstrb = 0; ddr_req = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!axi_rready && t < 20);
    chk("t5_reached_rwait", 64'(axi_rready), 1);
    reset = 1;
    #1;
    chk("t5_async_outs", {ddr_ready, ddr_busy, err, axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 0);
    chk("t5_async_rdata", ddr_rdata, 0);
    ddr_req = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    r_dly = 0; rdata_c = 64'hABCD;
    txn(32'h1000_0040, 0, 0, 64'hABCD, 3);
    chk("t5_err_after", err, 0);
    ar0 = ar_hs;
`ifdef DDR_ADDR_CHECK_EN
    txn(32'h4000_0000, 0, 0, 0, 2);
    chk("t6_no_ar", 64'(ar_hs), 64'(ar0));
    chk("t6_err", err, 1);
`else
    rdata_c = 64'h4444;
    txn(32'h4000_0000, 0, 0, 64'h4444, 3);
    chk("t6_ar_hs", 64'(ar_hs), 64'(ar0 + 1));
    chk("t6_araddr", last_araddr, 32'h4000_0000);
    chk("t6_err", err, 0);
`endif
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
    chk("ready_count", 64'(readys), 64'(n_txn));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
